// File: rtl/mul256_seq_if.sv
// Avalon-MM link between the mul256 sequencer (master) and the mul256 ALU slave port.
interface mul256_seq_if;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, writedata, byteenable, write, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, write, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mul256_seq.sv
// Microprogram sequencer: steps through a small RAM of ALU command words and
// issues each one to the mul256 ALU, polling for completion and optional skips.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; program RAM writable
// FETCH    | RAM[pc] being read
// ISSUE    | writing command word to the ALU control register
// POLL     | reading control register until bit 31 (busy) clears
// POLL_GAP | one-cycle read gap between busy polls
// STAT     | reading status register to decide a skip
// NEXT     | advance pc, detect end of program or run-off
// DONE     | one-cycle done pulse
module mul256_seq #(
    parameter int          DEPTH_LOG2 = 5,
    parameter logic [31:0] CTRL_ADDR  = 32'h0000_1000,
    parameter logic [31:0] STAT_ADDR  = 32'h0000_1004
) (
    input  logic                  hclk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [33:0]           prog_wdata,
    input  logic                  start,
    input  logic [DEPTH_LOG2-1:0] start_pc,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            op_count,
    mul256_seq_if.master          m
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        POLL,
        POLL_GAP,
        STAT,
        NEXT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [33:0]           mem [DEPTH];
    logic [33:0]           instr;
    logic [DEPTH_LOG2-1:0] pc;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  skip;
    logic [1:0]            flow;
    logic                  accept;
    logic [DEPTH_LOG2:0]   pc_next;

    assign flow    = instr[33:32];
    assign accept  = !m.waitrequest;
    // Extra MSB catches stepping past the last address
    assign pc_next = {1'b0, pc} + (DEPTH_LOG2 + 1)'(skip ? 2 : 1);

    // Single port: reads only happen in FETCH, writes only while not busy
    assign ram_addr = (state == FETCH) ? pc : prog_addr;

    always_ff @(posedge hclk) begin
        if (prog_we && !busy) begin
            mem[ram_addr] <= prog_wdata;
        end
        if (state == FETCH) begin
            instr <= mem[ram_addr];
        end
    end

    always_ff @(posedge hclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge hclk) begin
        if (rst) begin
            pc       <= '0;
            err      <= 1'b0;
            op_count <= 8'd0;
            skip     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc       <= start_pc;
                        err      <= 1'b0;
                        op_count <= 8'd0;
                    end
                end
                FETCH: skip <= 1'b0;
                ISSUE: begin
                    if (accept && op_count != 8'hFF) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                STAT: begin
                    if (accept) begin
                        skip <= flow[0] ? m.readdata[31] : (m.readdata == 32'd0);
                    end
                end
                NEXT: begin
                    if (flow != 2'b01) begin
                        if (pc_next[DEPTH_LOG2]) begin
                            err <= 1'b1;
                        end else begin
                            pc <= pc_next[DEPTH_LOG2-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b1;
        done         = 1'b0;
        m.write      = 1'b0;
        m.read       = 1'b0;
        m.address    = CTRL_ADDR;
        m.writedata  = 32'd0;
        m.byteenable = 4'h0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = ISSUE;
            ISSUE: begin
                m.write      = 1'b1;
                m.writedata  = instr[31:0];
                m.byteenable = 4'hF;
                if (accept) begin
                    state_nxt = POLL;
                end
            end
            POLL: begin
                m.read = 1'b1;
                if (accept) begin
                    if (m.readdata[31]) begin
                        state_nxt = POLL_GAP;
                    end else if (flow[1]) begin
                        state_nxt = STAT;
                    end else begin
                        state_nxt = NEXT;
                    end
                end
            end
            POLL_GAP: state_nxt = POLL;
            STAT: begin
                m.read    = 1'b1;
                m.address = STAT_ADDR;
                if (accept) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (flow == 2'b01 || pc_next[DEPTH_LOG2]) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul256_seq.sv
// Bench for mul256_seq: Avalon slave model plus a transaction scoreboard fed by a program model.
module tb_mul256_seq;

    localparam logic [31:0] CTRL = 32'h0000_1000;
    localparam logic [31:0] STAT = 32'h0000_1004;

    logic        hclk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [33:0] prog_wdata;
    logic        start;
    logic [4:0]  start_pc;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  op_count;

    mul256_seq_if bus();

    mul256_seq dut (
        .hclk       (hclk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .start_pc   (start_pc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .op_count   (op_count),
        .m          (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        sb[$];
    logic [33:0] img [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ws_write = 0;
    int          busy_polls = 0;
    logic [31:0] stat_val = 32'd0;
    int          pend = 0;
    int          busy_left = 0;
    bit          last_busy = 1'b0;
    int          last_rd_cyc = 0;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.wr   = wr;
        t.addr = addr;
        t.data = wr ? data : 32'd0;
        sb.push_back(t);
    endtask

    task automatic accept_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        if (sb.size() == 0) begin
            check_val("sb_extra", {31'd0, wr, addr}, 64'd0);
        end else begin
            t = sb.pop_front();
            check_val(wr ? "sb_write" : "sb_read", {31'd0, wr, addr}, {31'd0, t.wr, t.addr});
            if (wr) check_val("sb_wdata", data, t.data);
        end
    endtask

    // Slave response computed mid-cycle; the DUT samples it at the next rising edge.
    task automatic slave_step();
        bus.waitrequest = 1'b0;
        bus.readdata    = 32'd0;
        if (rst) begin
            pend = 0;
            return;
        end
        if (bus.write && bus.read) check_val("wr_rd_excl", 1, 0);
        if (bus.write) begin
            if (pend == 0) begin
                st_addr = bus.address;
                st_data = bus.writedata;
            end else begin
                check_val("stall_addr", bus.address, st_addr);
                check_val("stall_data", bus.writedata, st_data);
                check_val("stall_be", bus.byteenable, 4'hF);
            end
            if (pend < ws_write) begin
                bus.waitrequest = 1'b1;
                pend++;
            end else begin
                pend      = 0;
                busy_left = busy_polls;
                last_busy = 1'b0;
                accept_txn(1'b1, bus.address, bus.writedata);
            end
        end else if (bus.read) begin
            if (bus.address == CTRL) begin
                if (last_busy) check_val("poll_gap", cyc - last_rd_cyc, 2);
                last_busy    = (busy_left > 0);
                bus.readdata = last_busy ? 32'h8000_5a5a : 32'h0000_1234;
                if (busy_left > 0) busy_left--;
                last_rd_cyc  = cyc;
            end else begin
                bus.readdata = stat_val;
            end
            accept_txn(1'b0, bus.address, 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge hclk);
        cyc++;
        slave_step();
    endtask

    task automatic load(input int addr, input logic [33:0] word);
        prog_we    = 1'b1;
        prog_addr  = 5'(addr);
        prog_wdata = word;
        tick();
        prog_we    = 1'b0;
        img[addr]  = word;
    endtask

    task automatic model(input int spc, output int n_ops, output bit e_err, output int e_cyc);
        int          pc;
        bit          fin;
        bit          skp;
        logic [33:0] w;
        pc    = spc;
        fin   = 1'b0;
        n_ops = 0;
        e_err = 1'b0;
        e_cyc = 0;
        for (int k = 0; k < 64 && !fin; k++) begin
            w   = img[pc];
            skp = 1'b0;
            push_txn(1'b1, CTRL, w[31:0]);
            for (int r = 0; r <= busy_polls; r++) push_txn(1'b0, CTRL, 32'd0);
            n_ops++;
            e_cyc += 1 + (ws_write + 1) + (2 * busy_polls + 1) + 1;
            if (w[33]) begin
                push_txn(1'b0, STAT, 32'd0);
                e_cyc++;
                skp = w[32] ? stat_val[31] : (stat_val == 32'd0);
            end
            if (w[33:32] == 2'b01) begin
                fin = 1'b1;
            end else begin
                pc = pc + 1 + (skp ? 1 : 0);
                if (pc > 31) begin
                    e_err = 1'b1;
                    fin   = 1'b1;
                end
            end
        end
        e_cyc += 1;
    endtask

    task automatic run(input int spc, input bit wos, input logic [33:0] wword, input bit inject);
        int n_ops;
        int e_cyc;
        int c;
        bit e_err;
        bit seen;
        if (wos) img[spc] = wword;
        model(spc, n_ops, e_err, e_cyc);
        start    = 1'b1;
        start_pc = 5'(spc);
        if (wos) begin
            prog_we    = 1'b1;
            prog_addr  = 5'(spc);
            prog_wdata = wword;
        end
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        check_val("busy_run", busy, 1);
        check_val("err_clr", err, 0);
        c    = 1;
        seen = 1'b0;
        while (c < 2000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inject && c == 3) begin
                start      = 1'b1;
                start_pc   = 5'd5;
                prog_we    = 1'b1;
                prog_addr  = 5'(spc + 1);
                prog_wdata = {2'b01, 32'hBAD0_BAD0};
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            tick();
            c++;
        end
        start   = 1'b0;
        prog_we = 1'b0;
        check_val("done_seen", seen, 1);
        check_val("done_cyc", c, e_cyc);
        check_val("busy_done", busy, 0);
        check_val("op_count", op_count, n_ops);
        check_val("err", err, e_err);
        check_val("sb_empty", sb.size(), 0);
        tick();
        check_val("done_pulse", done, 0);
    endtask

    initial begin
        int  n_ops;
        int  e_cyc;
        bit  e_err;
        bit  reached;
        rst        = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = 5'd0;
        prog_wdata = 34'd0;
        start      = 1'b0;
        start_pc   = 5'd0;
        for (int i = 0; i < 32; i++) img[i] = 34'd0;
        repeat (3) tick();

        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_opcnt", op_count, 0);
        check_val("rst_write", bus.write, 0);
        check_val("rst_read", bus.read, 0);
        check_val("rst_addr", bus.address, CTRL);
        check_val("rst_wdata", bus.writedata, 0);
        check_val("rst_be", bus.byteenable, 0);
        rst = 1'b0;
        tick();

        // Single op; the real word lands in RAM on the start cycle itself
        load(0, {2'b01, 32'h1111_1111});
        run(0, 1'b1, {2'b01, 32'h9280_8088}, 1'b0);

        ws_write = 7;
        run(0, 1'b0, 34'd0, 1'b0);
        ws_write = 0;

        busy_polls = 3;
        load(0, {2'b00, 32'hA0A0_0001});
        load(1, {2'b01, 32'hA0A0_0002});
        run(0, 1'b0, 34'd0, 1'b0);
        busy_polls = 0;

        load(0, {2'b10, 32'hC000_0000});
        load(1, {2'b00, 32'hC000_0001});
        load(2, {2'b01, 32'hC000_0002});
        stat_val = 32'h0000_0000;
        run(0, 1'b0, 34'd0, 1'b0);
        stat_val = 32'h0000_0001;
        run(0, 1'b0, 34'd0, 1'b0);
        load(0, {2'b11, 32'hC000_0000});
        stat_val = 32'hFFFF_FFFF;
        run(0, 1'b0, 34'd0, 1'b0);
        stat_val = 32'h0000_0000;
        run(0, 1'b0, 34'd0, 1'b0);

        load(31, {2'b00, 32'hD000_001F});
        run(31, 1'b0, 34'd0, 1'b0);
        run(0, 1'b0, 34'd0, 1'b0);

        // Start and program write while busy must both be dropped
        load(0, {2'b00, 32'hE000_0000});
        load(1, {2'b01, 32'hE000_0001});
        busy_polls = 3;
        run(0, 1'b0, 34'd0, 1'b1);

        busy_polls = 100;
        model(0, n_ops, e_err, e_cyc);
        start    = 1'b1;
        start_pc = 5'd0;
        tick();
        start   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.read && bus.address == CTRL) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check_val("reach_poll", reached, 1);
        rst = 1'b1;
        tick();
        check_val("mrst_read", bus.read, 0);
        check_val("mrst_write", bus.write, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_done", done, 0);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mrst_nodone", done, 0);
            check_val("mrst_idle", busy, 0);
        end
        busy_polls = 0;
        run(0, 1'b0, 34'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
